// File: rtl/board_commit_scheduler.sv
// board_commit_scheduler: buffers tic-tac-toe move requests and applies them
// to the purple/gold occupancy registers only during vertical blanking.
// Moves are validated when popped, against the board as it stands that cycle.
// A START clear is latched and applied on the next vblank-high cycle.
module board_commit_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int SQUARES    = 9
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          req_valid,
   input  logic                          req_player,
   input  logic [3:0]                    req_square,
   output logic                          req_ready,
   input  logic                          clear_req,
   input  logic                          vblank,
   input  logic                          lock,
   output logic [SQUARES-1:0]            purp_state,
   output logic [SQUARES-1:0]            gold_state,
   output logic                          turn,
   output logic                          commit_pulse,
   output logic                          reject_pulse,
   output logic [1:0]                    reject_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          clear_pending
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [3:0]    MAX_SQ   = 4'(SQUARES - 1);

   typedef struct packed {
      logic       player;
      logic [3:0] square;
   } move_t;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   state_t              state, state_nxt;
   move_t               fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic                push, pop, clear_go;
   move_t               head;
   logic [SQUARES-1:0]  occ, sq_bit;
   logic                chk_pass;
   logic [1:0]          chk_code;

   // Acceptance depends only on registered state, so the source sees a stable ready.
   assign req_ready = (fifo_count < FULL_CNT) && !clear_pending;
   assign push      = req_valid && req_ready;

   // A pending clear wins over draining; once latched no more moves are popped.
   assign clear_go  = vblank && clear_pending && (state != CLEAR);
   assign pop       = vblank && !clear_pending && (state != CLEAR) && (fifo_count != '0);

   assign head   = fifo_mem[rd_ptr];
   assign occ    = purp_state | gold_state;
   assign sq_bit = SQUARES'(1) << head.square;

   // Validate the head entry in priority order: lock, index, occupancy, turn.
   always_comb begin
      chk_pass = 1'b0;
      chk_code = 2'b00;
      if (lock)                        chk_code = 2'b00;
      else if (head.square > MAX_SQ)   chk_code = 2'b01;
      else if ((occ & sq_bit) != '0)   chk_code = 2'b10;
      else if (head.player != turn)    chk_code = 2'b11;
      else                             chk_pass = 1'b1;
   end

   // Next-state: IDLE waits for blanking, DRAIN pops, CLEAR is a one-cycle quiet slot.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clear_go)                              state_nxt = CLEAR;
            else if (vblank && (fifo_count != '0))     state_nxt = DRAIN;
         end
         DRAIN: begin
            if (clear_go)                              state_nxt = CLEAR;
            else if (!vblank || (fifo_count == '0))    state_nxt = IDLE;
         end
         CLEAR:                                        state_nxt = IDLE;
         default:                                      state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Entry storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{player: req_player, square: req_square};
   end

   // FIFO pointers and occupancy; a clear flushes everything without pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (clear_go) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Board, turn and result pulses update on the edge after the pop cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         purp_state   <= '0;
         gold_state   <= '0;
         turn         <= 1'b0;
         commit_pulse <= 1'b0;
         reject_pulse <= 1'b0;
         reject_code  <= 2'b00;
      end else if (clear_go) begin
         purp_state   <= '0;
         gold_state   <= '0;
         turn         <= 1'b0;
         commit_pulse <= 1'b0;
         reject_pulse <= 1'b0;
      end else begin
         commit_pulse <= pop && chk_pass;
         reject_pulse <= pop && !chk_pass;
         if (pop && !chk_pass) reject_code <= chk_code;
         if (pop && chk_pass) begin
            if (head.player) gold_state <= gold_state | sq_bit;
            else             purp_state <= purp_state | sq_bit;
            turn <= ~turn;
         end
      end
   end

   // Clear request latch; repeated requests while pending are absorbed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       clear_pending <= 1'b0;
      else if (clear_go)  clear_pending <= 1'b0;
      else if (clear_req) clear_pending <= 1'b1;
   end

endmodule

// File: tb/tb_board_commit_scheduler.sv
// Bench for board_commit_scheduler: directed scenarios plus a randomized run,
// all checked against a queue-based move model of the commit rules.
module tb_board_commit_scheduler;

   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_player = 1'b0;
   logic [3:0] req_square = '0;
   logic       req_ready;
   logic       clear_req = 1'b0;
   logic       vblank = 1'b0;
   logic       lock = 1'b0;
   logic [8:0] purp_state, gold_state;
   logic       turn, commit_pulse, reject_pulse, clear_pending;
   logic [1:0] reject_code;
   logic [2:0] fifo_count;

   int errors = 0;
   int checks = 0;

   board_commit_scheduler #(.FIFO_DEPTH(FD), .SQUARES(9)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_player(req_player), .req_square(req_square),
      .req_ready(req_ready), .clear_req(clear_req), .vblank(vblank), .lock(lock),
      .purp_state(purp_state), .gold_state(gold_state), .turn(turn),
      .commit_pulse(commit_pulse), .reject_pulse(reject_pulse),
      .reject_code(reject_code), .fifo_count(fifo_count),
      .clear_pending(clear_pending)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       p;
      logic [3:0] sq;
   } mv_t;

   mv_t        mq[$];
   logic [8:0] m_purp, m_gold;
   logic       m_turn, m_pend, m_in_clear, m_commit, m_reject;
   logic [1:0] m_code;

   function automatic void model_reset();
      mq.delete();
      m_purp = '0; m_gold = '0; m_turn = 0; m_pend = 0; m_in_clear = 0;
      m_commit = 0; m_reject = 0; m_code = 2'b00;
   endfunction

   function automatic bit model_ready();
      return (mq.size() < FD) && !m_pend;
   endfunction

   // One clock of game rules using the inputs presented for the coming edge.
   function automatic void model_step();
      bit         acc;
      mv_t        mv;
      logic [8:0] bitm;
      acc = req_valid && model_ready();
      m_commit = 0;
      m_reject = 0;
      if (!m_in_clear && vblank && m_pend) begin
         m_purp = '0; m_gold = '0; m_turn = 0;
         mq.delete();
         m_pend = 0;
         m_in_clear = 1;
      end else begin
         if (!m_in_clear && vblank && mq.size() > 0) begin
            mv = mq.pop_front();
            bitm = 9'(1) << mv.sq;
            if (lock)                              begin m_reject = 1; m_code = 2'd0; end
            else if (mv.sq > 8)                    begin m_reject = 1; m_code = 2'd1; end
            else if (((m_purp | m_gold) & bitm) != 0) begin m_reject = 1; m_code = 2'd2; end
            else if (mv.p != m_turn)               begin m_reject = 1; m_code = 2'd3; end
            else begin
               if (mv.p) m_gold = m_gold | bitm;
               else      m_purp = m_purp | bitm;
               m_turn = !m_turn;
               m_commit = 1;
            end
         end
         m_in_clear = 0;
         if (clear_req) m_pend = 1;
         if (acc) begin
            mv.p = req_player;
            mv.sq = req_square;
            mq.push_back(mv);
         end
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic p, input logic [3:0] sq);
      req_valid = 1; req_player = p; req_square = sq;
      tick();
      req_valid = 0;
   endtask

   task automatic flush_board();
      vblank = 0;
      clear_req = 1;
      tick();
      clear_req = 0;
      vblank = 1;
      tick();
      tick();
      vblank = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({purp_state, gold_state, turn, commit_pulse, reject_pulse, reject_code, fifo_count, clear_pending} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got purp=%h gold=%h turn=%b cnt=%0d pend=%b", purp_state, gold_state, turn, fifo_count, clear_pending);
      end
      @(negedge clk);
      reset_n = 1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_single_commit();
      vblank = 0;
      push_req(0, 4'd4);
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
      checks++;
      if (purp_state !== 9'h000) begin errors++; $display("FAIL single_noearly got=%h exp=000", purp_state); end
      vblank = 1;
      tick();
      checks++;
      if (purp_state !== 9'h010 || turn !== 1'b1 || commit_pulse !== 1'b1) begin
         errors++;
         $display("FAIL single_commit got purp=%h turn=%b commit=%b exp purp=010 turn=1 commit=1", purp_state, turn, commit_pulse);
      end
      vblank = 0;
      tick();
      checks++;
      if (commit_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", commit_pulse); end
   endtask

   task automatic test_rejects();
      mv_t  mv[4];
      logic exp_c[5];
      logic [1:0] exp_code[5];
      mv[0] = '{p: 1'b0, sq: 4'd0};
      mv[1] = '{p: 1'b1, sq: 4'd0};
      mv[2] = '{p: 1'b1, sq: 4'd9};
      mv[3] = '{p: 1'b0, sq: 4'd3};
      exp_c[1] = 1; exp_c[2] = 0; exp_c[3] = 0; exp_c[4] = 0;
      exp_code[1] = 2'd0; exp_code[2] = 2'b10; exp_code[3] = 2'b01; exp_code[4] = 2'b11;
      flush_board();
      vblank = 1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            req_valid = 1; req_player = mv[i].p; req_square = mv[i].sq;
         end else req_valid = 0;
         tick();
         if (i > 0) begin
            checks++;
            if (commit_pulse !== exp_c[i] || reject_pulse !== !exp_c[i] ||
                (!exp_c[i] && reject_code !== exp_code[i])) begin
               errors++;
               $display("FAIL reject_seq[%0d] got c=%b r=%b code=%b exp c=%b code=%b", i, commit_pulse, reject_pulse, reject_code, exp_c[i], exp_code[i]);
            end
         end
      end
      req_valid = 0;
      vblank = 0;
      checks++;
      if (purp_state !== 9'h001 || gold_state !== 9'h000 || turn !== 1'b1) begin
         errors++;
         $display("FAIL reject_board got purp=%h gold=%h turn=%b exp 001 000 1", purp_state, gold_state, turn);
      end
   endtask

   task automatic test_full_partial();
      flush_board();
      push_req(0, 4'd0);
      push_req(1, 4'd1);
      push_req(0, 4'd2);
      push_req(1, 4'd3);
      req_valid = 1; req_player = 0; req_square = 4'd4;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", req_ready); end
      tick();
      checks++;
      if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
      req_valid = 0;
      vblank = 1;
      tick();
      tick();
      vblank = 0;
      tick();
      checks++;
      if (fifo_count !== 3'd2 || purp_state !== 9'h001 || gold_state !== 9'h002 || turn !== 1'b0) begin
         errors++;
         $display("FAIL partial_drain got cnt=%0d purp=%h gold=%h turn=%b exp 2 001 002 0", fifo_count, purp_state, gold_state, turn);
      end
   endtask

   task automatic test_lock();
      lock = 1;
      vblank = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (reject_pulse !== 1'b1 || reject_code !== 2'b00 || commit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL lock_reject[%0d] got r=%b code=%b c=%b exp r=1 code=00", i, reject_pulse, reject_code, commit_pulse);
         end
      end
      vblank = 0;
      lock = 0;
      tick();
      checks++;
      if (purp_state !== 9'h001 || gold_state !== 9'h002 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL lock_board got purp=%h gold=%h cnt=%0d exp 001 002 0", purp_state, gold_state, fifo_count);
      end
   endtask

   task automatic test_clear();
      push_req(0, 4'd2);
      push_req(1, 4'd3);
      push_req(0, 4'd4);
      clear_req = 1;
      tick();
      clear_req = 0;
      checks++;
      if (clear_pending !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_latch got pend=%b ready=%b exp 1 0", clear_pending, req_ready);
      end
      vblank = 1;
      tick();
      checks++;
      if (purp_state !== 9'h000 || gold_state !== 9'h000 || turn !== 1'b0 || fifo_count !== 3'd0 ||
          clear_pending !== 1'b0 || commit_pulse !== 1'b0 || reject_pulse !== 1'b0) begin
         errors++;
         $display("FAIL clear_apply got purp=%h gold=%h turn=%b cnt=%0d pend=%b c=%b r=%b exp all 0", purp_state, gold_state, turn, fifo_count, clear_pending, commit_pulse, reject_pulse);
      end
      tick();
      checks++;
      if (commit_pulse !== 1'b0 || reject_pulse !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL clear_quiet got c=%b r=%b cnt=%0d exp 0 0 0", commit_pulse, reject_pulse, fifo_count);
      end
      vblank = 0;
   endtask

   task automatic test_reset_mid_drain();
      push_req(0, 4'd4);
      push_req(1, 4'd0);
      push_req(0, 4'd8);
      vblank = 1;
      tick();
      checks++;
      if (purp_state !== 9'h010) begin errors++; $display("FAIL middrain_first got=%h exp=010", purp_state); end
      #2;
      reset_n = 0;
      #1;
      checks++;
      if ({purp_state, gold_state, turn, commit_pulse, reject_pulse, reject_code, fifo_count, clear_pending} !== '0) begin
         errors++;
         $display("FAIL async_reset got purp=%h gold=%h turn=%b c=%b cnt=%0d", purp_state, gold_state, turn, commit_pulse, fifo_count);
      end
      model_reset();
      @(posedge clk);
      #1;
      vblank = 0;
      reset_n = 1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
      vblank = 1;
      tick();
      vblank = 0;
      checks++;
      if (fifo_count !== 3'd0 || purp_state !== 9'h000 || commit_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush got cnt=%0d purp=%h c=%b exp 0 000 0", fifo_count, purp_state, commit_pulse);
      end
   endtask

   task automatic test_random();
      bit exp_ready;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) vblank = ~vblank;
         req_valid  = ($urandom_range(0, 2) != 0);
         req_player = ($urandom_range(0, 3) == 0) ? ~m_turn : m_turn;
         req_square = 4'($urandom_range(0, 10));
         clear_req  = ($urandom_range(0, 39) == 0);
         lock       = ($urandom_range(0, 15) == 0);
         #1;
         exp_ready = model_ready();
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL rand_ready[%0d] got=%b exp=%b", n, req_ready, exp_ready);
         end
         tick();
         checks++;
         if (purp_state !== m_purp || gold_state !== m_gold || turn !== m_turn) begin
            errors++;
            $display("FAIL rand_board[%0d] got %h %h %b exp %h %h %b", n, purp_state, gold_state, turn, m_purp, m_gold, m_turn);
         end
         checks++;
         if (commit_pulse !== m_commit || reject_pulse !== m_reject || reject_code !== m_code) begin
            errors++;
            $display("FAIL rand_pulse[%0d] got c=%b r=%b code=%b exp c=%b r=%b code=%b", n, commit_pulse, reject_pulse, reject_code, m_commit, m_reject, m_code);
         end
         checks++;
         if (fifo_count !== 3'(mq.size()) || clear_pending !== m_pend) begin
            errors++;
            $display("FAIL rand_fifo[%0d] got cnt=%0d pend=%b exp cnt=%0d pend=%b", n, fifo_count, clear_pending, mq.size(), m_pend);
         end
      end
      req_valid = 0; clear_req = 0; lock = 0; vblank = 0;
   endtask

   initial begin
      test_reset();
      test_single_commit();
      test_rejects();
      test_full_partial();
      test_lock();
      test_clear();
      test_reset_mid_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_commit_scheduler.md
# board_commit_scheduler

Sequences tic-tac-toe move commits into the board registers that drive the Display block. Move requests from the game/controller side are buffered in a small FIFO and applied only during vertical blanking, so the rendered frame never tears mid-scan. The block validates each move (index, occupancy, turn order, game lock) at commit time. It also schedules a frame-aligned board clear for the START button.

## Interface
Parameters:
- FIFO_DEPTH, 4: move request buffer entries (power of two, ≥2).
- SQUARES, 9: board cells; fixed at 9 for this design.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, CLOCK_50 domain.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  move request present.
- req_player  in  1  0 = purple, 1 = gold.
- req_square  in  4  target cell 0..8.
- req_ready  out  1  request accepted on this cycle when high with req_valid.
- clear_req  in  1  single-cycle pulse requesting a board clear.
- vblank  in  1  high while the video driver is outside the visible area (y ≥ 480); same clock domain.
- lock  in  1  game_finished from win logic; moves are rejected while high.
- purp_state  out  9  purple occupancy, bit n = cell n.
- gold_state  out  9  gold occupancy.
- turn  out  1  player expected next, 0 = purple.
- commit_pulse  out  1  one cycle per applied move.
- reject_pulse  out  1  one cycle per discarded move.
- reject_code  out  2  valid with reject_pulse: 00 locked, 01 bad index, 10 occupied, 11 wrong turn.
- fifo_count  out  log2(FIFO_DEPTH)+1  entries buffered.
- clear_pending  out  1  clear latched, not yet applied.

## Operation
- Enqueue: {req_player, req_square} pushed when req_valid && req_ready. req_ready = (fifo_count < FIFO_DEPTH) && !clear_pending, combinational from registered state.
- No validation at enqueue; all checks at pop, against board state current at that cycle.
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE → CLEAR when vblank && clear_pending. This has priority.
  - IDLE → DRAIN when vblank && fifo_count > 0.
  - DRAIN: pops one entry per cycle while vblank high and FIFO non-empty.
    - Goes to CLEAR if clear_pending.
    - Goes to IDLE on vblank low or FIFO empty.
  - CLEAR: one cycle. Zeroes purp_state/gold_state, sets turn = 0, flushes FIFO, drops clear_pending, then returns to IDLE.
- Pop check priority: lock → 00; req_square > 8 → 01; bit set in purp|gold → 10; player ≠ turn → 11.
  - Pass: set the player's bit, toggle turn, commit_pulse.
  - Fail: reject_pulse with code; board and turn are unchanged.
- clear_req while clear_pending is already high has no additional effect. Flushed entries produce no reject pulses.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: purp_state = 0, gold_state = 0, turn = 0, commit_pulse = 0, reject_pulse = 0, reject_code = 00, fifo_count = 0, clear_pending = 0, FSM = IDLE. req_ready = 1 after reset.
- All outputs except req_ready are registered.
- Board and turn change on the clock edge after the pop cycle. commit_pulse and reject_pulse are asserted in that same following cycle.
- First pop happens on the first cycle vblank is sampled high. This means one cycle of latency from the vblank rise to the first board update.
- clear_req is latched on the edge where it is sampled high. clear_pending rises the next cycle, so req_ready falls the next cycle.
- Clear applies on the first vblank-high cycle after latching, including the case where vblank is already high.
- vblank falling mid-drain: the entry popped in that cycle is not popped. Remaining entries wait for the next blanking interval.
- Full FIFO: req_ready low; a request is held by the source and is not lost.
- Reset mid-drain or mid-clear: immediate return to reset values; the FIFO is emptied.

## Test plan
- After reset, vblank = 0, push purple sq 4 → fifo_count = 1, board stays 0. Raise vblank → purp_state = 9'h010, turn = 1, one commit_pulse.
- During one vblank, push purple 0, gold 0, gold 9, purple 3 → commits: purp 9'h001; gold 0 rejected with 10; gold 9 rejected with 01; purple 3 rejected with 11. Final turn = 1.
- Fill FIFO with 4 entries while vblank = 0 → req_ready = 0 on the 5th request. Drop vblank after 2 pops → fifo_count = 2, board reflects only 2 moves.
- With lock = 1, drain 2 entries → two reject_pulse with code 00; board unchanged.
- Board nonzero, 3 entries queued, pulse clear_req, raise vblank → next cycle board = 0, turn = 0, fifo_count = 0, no commit/reject pulses.
- Assert reset_n low mid-drain → all outputs at reset values asynchronously. After release, req_ready = 1.
